// File: rtl/turbo_mem_xfer.sv
// turbo_mem_xfer: ROM->RAM block copy engine with optional read-back verify.
// One word per clock; both memories return data RD_LAT clocks after address.
module turbo_mem_xfer #(
  parameter int D_WIDTH = 13,
  parameter int A_WIDTH = 16,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [A_WIDTH-1:0] src_base,
  input  logic [A_WIDTH-1:0] dst_base,
  input  logic [A_WIDTH-1:0] len,
  input  logic               abort,
  output logic [A_WIDTH-1:0] rom_addr,
  input  logic [D_WIDTH-1:0] rom_data,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic               ram_wen,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic [A_WIDTH-1:0] ram_raddr,
  input  logic [D_WIDTH-1:0] ram_rdata,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [A_WIDTH-1:0] err_cnt,
  output logic [A_WIDTH-1:0] first_err_off
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_CDRAIN,
    S_VERIFY,
    S_VDRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] DLAST = 2'(RD_LAT - 1);
  localparam logic [A_WIDTH-1:0] ONES = '1;
  localparam logic [A_WIDTH-1:0] ONE = A_WIDTH'(1);

  state_e state_q, state_d;
  logic [A_WIDTH-1:0] off_q, off_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic [A_WIDTH-1:0] src_q, dst_q, len_q;
  logic               vaft_q, abt_q;
  logic [A_WIDTH-1:0] err_q, ferr_q;

  logic [RD_LAT-1:0]  cv_q, vv_q;
  logic [A_WIDTH-1:0] coff_q [RD_LAT];
  logic [A_WIDTH-1:0] voff_q [RD_LAT];

  logic issue_c, issue_v;
  logic accept, flush, last, mism;
  logic [1:0] cdrain_last;

  assign accept = (state_q == S_IDLE) && start;
  assign flush  = abort && (state_q != S_IDLE);
  assign last   = (off_q == len_q - ONE);
  assign mism   = vv_q[RD_LAT-1] && (rom_data != ram_rdata);

  // one spacer clock before verify lets the final write settle in RAM
  assign cdrain_last = vaft_q ? DLAST + 2'd1 : DLAST;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    dcnt_d  = dcnt_q;
    issue_c = 1'b0;
    issue_v = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          off_d = '0;
          if (len == '0)
            state_d = S_DONE;
          else if (mode == 2'b01)
            state_d = S_VERIFY;
          else
            state_d = S_COPY;
        end
      end
      S_COPY: begin
        issue_c = 1'b1;
        off_d   = off_q + ONE;
        if (last) begin
          off_d   = '0;
          dcnt_d  = '0;
          state_d = S_CDRAIN;
        end
      end
      S_CDRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == cdrain_last) begin
          dcnt_d  = '0;
          state_d = vaft_q ? S_VERIFY : S_DONE;
        end
      end
      S_VERIFY: begin
        issue_v = 1'b1;
        off_d   = off_q + ONE;
        if (last) begin
          off_d   = '0;
          dcnt_d  = '0;
          state_d = S_VDRAIN;
        end
      end
      S_VDRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == DLAST) begin
          dcnt_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      vaft_q <= 1'b0;
      abt_q  <= 1'b0;
      err_q  <= '0;
      ferr_q <= ONES;
    end else if (accept) begin
      src_q  <= src_base;
      dst_q  <= dst_base;
      len_q  <= len;
      vaft_q <= (mode == 2'b10);
      abt_q  <= 1'b0;
      err_q  <= '0;
      ferr_q <= ONES;
    end else begin
      if (flush) abt_q <= 1'b1;
      if (mism) begin
        if (err_q != ONES) err_q <= err_q + ONE;
        if (err_q == '0) ferr_q <= voff_q[RD_LAT-1];
      end
    end
  end

  // abort flushes in-flight reads so no stale write lands afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv_q <= '0;
      vv_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        coff_q[k] <= '0;
        voff_q[k] <= '0;
      end
    end else begin
      cv_q[0]   <= issue_c & ~flush;
      vv_q[0]   <= issue_v & ~flush;
      coff_q[0] <= off_q;
      voff_q[0] <= off_q;
      for (int k = 1; k < RD_LAT; k++) begin
        cv_q[k]   <= cv_q[k-1] & ~flush;
        vv_q[k]   <= vv_q[k-1] & ~flush;
        coff_q[k] <= coff_q[k-1];
        voff_q[k] <= voff_q[k-1];
      end
    end
  end

  assign rom_addr  = (issue_c | issue_v) ? src_q + off_q : '0;
  assign ram_raddr = issue_v ? dst_q + off_q : '0;
  assign ram_wen   = cv_q[RD_LAT-1];
  assign ram_waddr = ram_wen ? dst_q + coff_q[RD_LAT-1] : '0;
  assign ram_wdata = ram_wen ? rom_data : '0;

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign aborted       = abt_q;
  assign err_cnt       = err_q;
  assign first_err_off = ferr_q;

endmodule

// File: tb/tb_turbo_mem_xfer.sv
// tb_turbo_mem_xfer: directed checks of copy/verify/abort on two
// instances, one with RD_LAT=1 and one with RD_LAT=2.
module tb_turbo_mem_xfer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode = '0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        start_a = 0, start_b = 0, abort_a = 0, abort_b = 0;

  logic [15:0] a_rom_addr, a_waddr, a_raddr, a_err, a_ferr;
  logic [12:0] a_rom_data, a_wdata, a_rdata;
  logic        a_wen, a_busy, a_done, a_abt;
  logic [15:0] b_rom_addr, b_waddr, b_raddr, b_err, b_ferr;
  logic [12:0] b_rom_data, b_wdata, b_rdata;
  logic        b_wen, b_busy, b_done, b_abt;

  logic [12:0] ram_a [65536];
  logic [12:0] ram_b [65536];
  logic [15:0] cor0 = 16'hFFFF, cor1 = 16'hFFFF;
  int a_wcnt = 0, a_dcnt = 0, b_wcnt = 0, b_dcnt = 0;
  int nchk = 0, nerr = 0;

  turbo_mem_xfer #(.D_WIDTH(13), .A_WIDTH(16), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode),
    .src_base(src), .dst_base(dst), .len(len), .abort(abort_a),
    .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .ram_waddr(a_waddr), .ram_wen(a_wen), .ram_wdata(a_wdata),
    .ram_raddr(a_raddr), .ram_rdata(a_rdata),
    .busy(a_busy), .done(a_done), .aborted(a_abt),
    .err_cnt(a_err), .first_err_off(a_ferr)
  );

  turbo_mem_xfer #(.D_WIDTH(13), .A_WIDTH(16), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode),
    .src_base(src), .dst_base(dst), .len(len), .abort(abort_b),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .ram_waddr(b_waddr), .ram_wen(b_wen), .ram_wdata(b_wdata),
    .ram_raddr(b_raddr), .ram_rdata(b_rdata),
    .busy(b_busy), .done(b_done), .aborted(b_abt),
    .err_cnt(b_err), .first_err_off(b_ferr)
  );

  function automatic logic [12:0] rom_val(input logic [15:0] a);
    return 13'((a * 37) ^ 32'h1A5);
  endfunction

  // read port of instance A flips bit 0 at the two corrupt addresses
  function automatic logic [12:0] rd_a(input logic [15:0] a);
    return ram_a[a] ^ ((a == cor0 || a == cor1) ? 13'h1 : 13'h0);
  endfunction

  logic [12:0] b_rom1, b_ram1;
  always @(posedge clk) begin
    a_rom_data <= rom_val(a_rom_addr);
    a_rdata    <= rd_a(a_raddr);
    b_rom1     <= rom_val(b_rom_addr);
    b_ram1     <= ram_b[b_raddr];
    b_rom_data <= b_rom1;
    b_rdata    <= b_ram1;
    if (a_wen) begin
      ram_a[a_waddr] <= a_wdata;
      a_wcnt <= a_wcnt + 1;
    end
    if (b_wen) begin
      ram_b[b_waddr] <= b_wdata;
      b_wcnt <= b_wcnt + 1;
    end
    if (a_done) a_dcnt <= a_dcnt + 1;
    if (b_done) b_dcnt <= b_dcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [1:0] m, input logic [15:0] s,
                       input logic [15:0] d, input logic [15:0] n);
    mode = m;
    src  = s;
    dst  = d;
    len  = n;
  endtask

  // returns the cycle (start edge = 0) on which done is seen
  task automatic wait_a(input int c0, output int cyc);
    cyc = c0;
    while (!a_done && cyc < 300) begin
      tick;
      cyc++;
    end
  endtask

  task automatic wait_b(input int c0, output int cyc);
    cyc = c0;
    while (!b_done && cyc < 300) begin
      tick;
      cyc++;
    end
  endtask

  int cyc, w0, d0;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    tick;
    tick;
    check("rst_busy", a_busy, 0);
    check("rst_ferr", a_ferr, 16'hFFFF);
    check("rst_err", a_err, 0);
    check("rst_abt", a_abt, 0);
    rst = 1'b0;
    tick;

    // reset in the middle of a 20-word copy
    setup(2'b00, 16'h0700, 16'h0800, 16'd20);
    start_a = 1;
    tick;
    start_a = 0;
    repeat (5) tick;
    check("t1_raddr", a_rom_addr, 16'h0705);
    check("t1_wen", a_wen, 1);
    check("t1_waddr", a_waddr, 16'h0804);
    rst = 1'b1;
    #1;
    check("t1_busy", a_busy, 0);
    check("t1_wen0", a_wen, 0);
    check("t1_ferr", a_ferr, 16'hFFFF);
    check("t1_romad", a_rom_addr, 0);
    check("t1_wdata", a_wdata, 0);
    check("t1_done", a_done, 0);
    tick;
    rst = 1'b0;
    tick;

    // basic copy, RD_LAT=1
    setup(2'b00, 16'h0010, 16'h0100, 16'd4);
    w0 = a_wcnt;
    start_a = 1;
    tick;
    start_a = 0;
    check("t2_busy", a_busy, 1);
    check("t2_rom0", a_rom_addr, 16'h0010);
    wait_a(1, cyc);
    check("t2_lat", cyc, 6);
    tick;
    check("t2_idle", a_busy, 0);
    check("t2_dlow", a_done, 0);
    tick;
    for (int k = 0; k < 4; k++)
      check("t2_word", ram_a[16'h0100 + k], rom_val(16'h0010 + k));
    check("t2_past", ram_a[16'h0104], 0);
    check("t2_wcnt", a_wcnt - w0, 4);
    check("t2_err", a_err, 0);

    // copy-then-verify with two corrupted read-back words
    cor0 = 16'h0303;
    cor1 = 16'h0306;
    setup(2'b10, 16'h0200, 16'h0300, 16'd8);
    d0 = a_dcnt;
    start_a = 1;
    tick;
    start_a = 0;
    wait_a(1, cyc);
    check("t3_lat", cyc, 20);
    tick;
    tick;
    check("t3_err", a_err, 2);
    check("t3_ferr", a_ferr, 3);
    check("t3_dcnt", a_dcnt - d0, 1);
    cor0 = 16'hFFFF;
    cor1 = 16'hFFFF;

    // address wrap at the top of the map
    setup(2'b00, 16'hFFFE, 16'hFFFF, 16'd3);
    start_a = 1;
    tick;
    start_a = 0;
    check("t4_ferr_clr", a_ferr, 16'hFFFF);
    check("t4_err_clr", a_err, 0);
    wait_a(1, cyc);
    check("t4_lat", cyc, 5);
    tick;
    tick;
    check("t4_w0", ram_a[16'hFFFF], rom_val(16'hFFFE));
    check("t4_w1", ram_a[16'h0000], rom_val(16'hFFFF));
    check("t4_w2", ram_a[16'h0001], rom_val(16'h0000));

    // zero length, then a start pulse that must be ignored while busy
    setup(2'b00, 16'h0400, 16'h0500, 16'd0);
    w0 = a_wcnt;
    start_a = 1;
    tick;
    start_a = 0;
    wait_a(1, cyc);
    check("t5_len0", cyc, 1);
    tick;
    tick;
    check("t5_nowr", a_wcnt - w0, 0);
    setup(2'b00, 16'h0400, 16'h0500, 16'd10);
    start_a = 1;
    tick;
    start_a = 0;
    tick;
    setup(2'b01, 16'h0000, 16'h0000, 16'd3);
    start_a = 1;
    tick;
    start_a = 0;
    wait_a(3, cyc);
    check("t5_lat", cyc, 12);
    tick;
    tick;
    check("t5_wcnt", a_wcnt - w0, 10);
    check("t5_last", ram_a[16'h0509], rom_val(16'h0409));
    check("t5_past", ram_a[16'h050A], 0);

    // abort on word 2, RD_LAT=2
    setup(2'b00, 16'h0020, 16'h0600, 16'd6);
    w0 = b_wcnt;
    d0 = b_dcnt;
    start_b = 1;
    tick;
    start_b = 0;
    tick;
    tick;
    check("t6_word2", b_rom_addr, 16'h0022);
    abort_b = 1;
    tick;
    abort_b = 0;
    check("t6_busy", b_busy, 0);
    check("t6_abt", b_abt, 1);
    check("t6_wen", b_wen, 0);
    repeat (8) tick;
    check("t6_nodone", b_dcnt - d0, 0);
    check("t6_wr_le3", (b_wcnt - w0) <= 3, 1);
    check("t6_abt_hold", b_abt, 1);

    // start with abort in IDLE: start wins, aborted clears
    setup(2'b10, 16'h0030, 16'h0640, 16'd2);
    start_b = 1;
    abort_b = 1;
    tick;
    start_b = 0;
    abort_b = 0;
    check("t6_restart", b_busy, 1);
    check("t6_abt_clr", b_abt, 0);
    wait_b(1, cyc);
    check("t6_cv_lat", cyc, 10);
    tick;
    tick;
    check("t6_cv_err", b_err, 0);
    check("t6_cv_ferr", b_ferr, 16'hFFFF);
    check("t6_cv_word", ram_b[16'h0641], rom_val(16'h0031));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
